// File: rtl/proc_pkg.sv
// Shared types and constants for the processor output-side serial blocks.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage

// File: rtl/shift_reg_piso.sv
// SIZE-bit parallel-load shift register that zero-fills as it drains toward
// the selected output end.
module shift_reg_piso #(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            load,
  input  logic            shift,
  input  logic [SIZE-1:0] D,
  output logic            outBit
);

  logic [SIZE-1:0] shreg;
  logic [SIZE-1:0] shifted;

  // The output end and the shift direction are chosen at elaboration time.
  if (MSB_FIRST) begin : gMsbFirst
    assign shifted = {shreg[SIZE-2:0], 1'b0};
    assign outBit  = shreg[SIZE-1];
  end else begin : gLsbFirst
    assign shifted = {1'b0, shreg[SIZE-1:1]};
    assign outBit  = shreg[0];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= D;
    end else if (shift) begin
      shreg <= shifted;
    end
  end

endmodule

// File: rtl/piso_shift_out.sv
// Parallel-in/serial-out reader: captures a word on load and streams it one
// bit per accepted valid/ready beat, reporting busy/done to the control unit.
import proc_pkg::*;

module piso_shift_out #(
  parameter int   SIZE      = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            load,
  input  logic [SIZE-1:0] D,
  output logic            sOut,
  output logic            sValid,
  input  logic            sReady,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(SIZE + 1);

  shift_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             shBit;
  logic             loadAccept;
  logic             beat;
  logic             lastBeat;

  // A load is only honoured when no word is in flight, so SHIFT never gets corrupted.
  assign loadAccept = load && ((state == IDLE) || (state == DONE));
  assign beat       = (state == SHIFT) && sReady;
  assign lastBeat   = beat && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (loadAccept) begin
            state <= SHIFT;
            cnt   <= CNT_W'(SIZE);
          end
        end
        SHIFT: begin
          if (beat) begin
            cnt <= cnt - CNT_W'(1);
            if (lastBeat) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (loadAccept) begin
            state <= SHIFT;
            cnt   <= CNT_W'(SIZE);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  shift_reg_piso #(
    .SIZE     (SIZE),
    .MSB_FIRST(MSB_FIRST)
  ) uShiftReg (
    .clk   (clk),
    .Reset (Reset),
    .load  (loadAccept),
    .shift (beat),
    .D     (D),
    .outBit(shBit)
  );

  // All status outputs decode straight from the registered state.
  assign sValid = (state == SHIFT);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign sOut   = sValid ? shBit : IDLE_BIT;

endmodule

// File: tb/tb_piso_shift_out.sv
// Directed bench for piso_shift_out: one MSB-first and one LSB-first instance.
module tb_piso_shift_out;

  logic       clk = 1'b0;
  logic       Reset;
  logic       load, sReady, load2, sReady2;
  logic [7:0] D, D2;
  logic       sOut, sValid, busy, done;
  logic       sOut2, sValid2, busy2, done2;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  piso_shift_out #(.SIZE(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dutMsb (
    .clk(clk), .Reset(Reset), .load(load), .D(D), .sOut(sOut),
    .sValid(sValid), .sReady(sReady), .busy(busy), .done(done)
  );

  piso_shift_out #(.SIZE(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutLsb (
    .clk(clk), .Reset(Reset), .load(load2), .D(D2), .sOut(sOut2),
    .sValid(sValid2), .sReady(sReady2), .busy(busy2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; load = 1'b0; load2 = 1'b0; D = '0; D2 = '0;
    sReady = 1'b0; sReady2 = 1'b0;
    step(); step();
    Reset = 1'b0;
    testsRun++;
    if ({sOut, sValid, busy, done} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL reset_msb: got sOut/sValid/busy/done=%b, want 1000", {sOut, sValid, busy, done});
    end
    testsRun++;
    if ({sOut2, sValid2, busy2, done2} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL reset_lsb: got sOut/sValid/busy/done=%b, want 1000", {sOut2, sValid2, busy2, done2});
    end
  endtask

  task automatic test_msb_stream();
    logic [7:0] word;
    word = 8'hA5;
    sReady = 1'b1; D = word; load = 1'b1;
    step();
    load = 1'b0; D = '0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (sOut !== word[7-i] || sValid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL msb_stream bit %0d: got sOut=%b sValid=%b busy=%b done=%b, want sOut=%b sValid=1 busy=1 done=0",
                 i, sOut, sValid, busy, done, word[7-i]);
      end
      step();
    end
    testsRun++;
    if (done !== 1'b1 || busy !== 1'b0 || sValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL msb_done: got done=%b busy=%b sValid=%b, want 1 0 0", done, busy, sValid);
    end
    step();
    testsRun++;
    if (done !== 1'b0 || sOut !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL msb_after_done: got done=%b sOut=%b, want 0 1", done, sOut);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] word;
    word = 8'h01;
    sReady2 = 1'b1; D2 = word; load2 = 1'b1;
    step();
    load2 = 1'b0; D2 = '0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (sOut2 !== word[i] || sValid2 !== 1'b1 || done2 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL lsb_stream bit %0d: got sOut=%b sValid=%b done=%b, want sOut=%b sValid=1 done=0",
                 i, sOut2, sValid2, done2, word[i]);
      end
      step();
    end
    testsRun++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || sValid2 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL lsb_done: got done=%b busy=%b sValid=%b, want 1 0 0", done2, busy2, sValid2);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] word;
    int idx;
    int cyc;
    word = 8'hF0;
    idx = 0; cyc = 0;
    sReady = 1'b1; D = word; load = 1'b1;
    step();
    load = 1'b0; D = '0;
    while (idx < 8 && cyc < 40) begin
      testsRun++;
      if (sOut !== word[7-idx] || sValid !== 1'b1 || done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL backpressure cycle %0d: got sOut=%b sValid=%b done=%b, want sOut=%b sValid=1 done=0",
                 cyc, sOut, sValid, done, word[7-idx]);
      end
      if (sReady) idx++;
      cyc++;
      step();
      sReady = ~sReady;
    end
    testsRun++;
    if (idx != 8 || cyc != 15) begin
      testsFailed++;
      $display("[TB] FAIL backpressure_count: got beats=%0d cycles=%0d, want 8 15", idx, cyc);
    end
    testsRun++;
    if (done !== 1'b1 || sValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL backpressure_done: got done=%b sValid=%b, want 1 0", done, sValid);
    end
    sReady = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h3C; w2 = 8'hC3;
    sReady = 1'b1; D = w1; load = 1'b1;
    step();
    load = 1'b0; D = '0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (sOut !== w1[7-i] || sValid !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_first bit %0d: got sOut=%b sValid=%b, want %b 1", i, sOut, sValid, w1[7-i]);
      end
      if (i == 2) begin
        load = 1'b1; D = 8'h00;
      end
      step();
      load = 1'b0; D = '0;
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_done1: got done=%b, want 1", done);
    end
    load = 1'b1; D = w2;
    step();
    load = 1'b0; D = '0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (sOut !== w2[7-i] || sValid !== 1'b1 || busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_second bit %0d: got sOut=%b sValid=%b busy=%b, want %b 1 1",
                 i, sOut, sValid, busy, w2[7-i]);
      end
      step();
    end
    testsRun++;
    if (done !== 1'b1 || sValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_done2: got done=%b sValid=%b, want 1 0", done, sValid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    sReady = 1'b1; D = 8'hFF; load = 1'b1;
    step();
    load = 1'b0; D = '0;
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (sOut !== 1'b1 || sValid !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_pre bit %0d: got sOut=%b sValid=%b, want 1 1", i, sOut, sValid);
      end
      step();
    end
    Reset = 1'b1; load = 1'b1; D = 8'hAA;
    step();
    Reset = 1'b0; load = 1'b0; D = '0;
    testsRun++;
    if ({sOut, sValid, busy, done} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got sOut/sValid/busy/done=%b, want 1000", {sOut, sValid, busy, done});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      testsRun++;
      if (done !== 1'b0 || sValid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_quiet cycle %0d: got done=%b sValid=%b, want 0 0", i, done, sValid);
      end
    end
  endtask

  task automatic test_idle();
    load = 1'b0; sReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      testsRun++;
      if (sValid !== 1'b0 || sOut !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL idle cycle %0d: got sValid=%b sOut=%b done=%b busy=%b, want 0 1 0 0",
                 i, sValid, sOut, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_stream();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
